// File: rtl/fuzzy_pkg.sv
// ----------------------------------------------------------------------------
// fuzzy_pkg
// Shared definitions for the fuzzy-processor input conditioning stage:
// sequencer state codes, the offset-binary zero point and the saturation limit.
// ----------------------------------------------------------------------------
package fuzzy_pkg;

    // Sequencer states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_RUN  = 2'd2;
    localparam state_t ST_GAP  = 2'd3;

    // Offset-binary zero: 128 encodes a signed value of 0
    localparam logic [7:0] ZERO_OFF = 8'd128;

    // Symmetric saturation limit applied before offset encoding
    localparam int SAT_MAX = 127;

endpackage

// File: rtl/fuzzy_sat_off.sv
// ----------------------------------------------------------------------------
// fuzzy_sat_off
// Combinational arithmetic-shift, saturate to [-SAT_MAX,+SAT_MAX] and
// offset-binary encode.
// Parameters: IN_W (input width, >= 8), SH (arithmetic right shift).
// Ports:
//   din  in  IN_W  signed input value
//   dsh  out IN_W  din >>> SH (before saturation)
//   dout out 8     saturated value + 128
// ----------------------------------------------------------------------------
module fuzzy_sat_off
    import fuzzy_pkg::*;
#(
    parameter int IN_W = 9,
    parameter int SH   = 0
) (
    input  logic signed [IN_W-1:0] din,
    output logic signed [IN_W-1:0] dsh,
    output logic        [7:0]      dout
);

    localparam logic signed [IN_W-1:0] SAT_HI = IN_W'(SAT_MAX);
    localparam logic signed [IN_W-1:0] SAT_LO = -SAT_HI;

    logic signed [IN_W-1:0] sat_s;

    // Shift, clamp, then move zero to 128; the clamped value fits in 8 bits,
    // so adding 128 modulo 256 is exact.
    always_comb begin
        dsh = din >>> SH;
        if (dsh > SAT_HI) begin
            sat_s = SAT_HI;
        end else if (dsh < SAT_LO) begin
            sat_s = SAT_LO;
        end else begin
            sat_s = dsh;
        end
        dout = sat_s[7:0] + ZERO_OFF;
    end

endmodule

// File: rtl/fuzzy_entrada_erro.sv
// ----------------------------------------------------------------------------
// fuzzy_entrada_erro
// Input conditioning for the type-2 fuzzy processor. Samples setpoint and
// measurement, computes error and change-of-error, encodes both as
// offset-binary crisp inputs, then holds EN_REGRAS high for N_REGRAS cycles
// followed by an N_GAP-cycle quiet gap.
// Optional feature: define FUZZY_ENTRADA_FILTRO_EN to pass the measurement
// through a 2-tap average (first sample after reset is taken unfiltered).
// Ports:
//   clk_0         in   1  clock, rising edge
//   Srst          in   1  asynchronous active-low reset
//   setpoint      in   8  unsigned reference
//   medida        in   8  unsigned plant measurement
//   medida_valid  in   1  strobe: setpoint/medida valid
//   Entrada_01    out  8  error, offset-binary
//   Entrada_02    out  8  change-of-error, offset-binary
//   EN_REGRAS     out  1  inference enable
//   pronto        out  1  ready to accept a sample
//   overrun       out  8  saturating count of dropped strobes
// ----------------------------------------------------------------------------
module fuzzy_entrada_erro
    import fuzzy_pkg::*;
#(
    parameter int N_REGRAS = 32,
    parameter int N_GAP    = 4,
    parameter int SH_ERRO  = 0,
    parameter int SH_DERRO = 0
) (
    input  logic       clk_0,
    input  logic       Srst,
    input  logic [7:0] setpoint,
    input  logic [7:0] medida,
    input  logic       medida_valid,
    output logic [7:0] Entrada_01,
    output logic [7:0] Entrada_02,
    output logic       EN_REGRAS,
    output logic       pronto,
    output logic [7:0] overrun
);

    localparam int N_MAX = (N_REGRAS > N_GAP) ? N_REGRAS : N_GAP;
    localparam int CNT_W = $clog2(N_MAX + 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(N_REGRAS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(N_GAP - 1);

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [7:0]         sp_q,       sp_d;
    logic [7:0]         pv_q,       pv_d;
    logic signed [8:0]  err_prev_q, err_prev_d;
    logic               first_q,    first_d;
    logic [7:0]         ent1_q,     ent1_d;
    logic [7:0]         ent2_q,     ent2_d;
    logic               en_q,       en_d;
    logic               pronto_q,   pronto_d;
    logic [7:0]         ovr_q,      ovr_d;

    logic [7:0]         pv_new_s;
    logic signed [8:0]  e_raw_s,  e_sh_s;
    logic signed [9:0]  de_raw_s, de_sh_s;
    logic [7:0]         e_enc_s,  de_enc_s;

`ifdef FUZZY_ENTRADA_FILTRO_EN
    logic [7:0] med_prev_q, med_prev_d;
    logic [8:0] pv_sum_s;

    // Rounded 2-tap average of the raw measurement; bypassed on the first sample
    always_comb begin
        pv_sum_s = {1'b0, medida} + {1'b0, med_prev_q} + 9'd1;
        if (first_q) begin
            pv_new_s = medida;
        end else begin
            pv_new_s = pv_sum_s[8:1];
        end
    end

    // Previous raw measurement, advanced only on accepted samples
    always_ff @(posedge clk_0 or negedge Srst) begin
        if (!Srst) begin
            med_prev_q <= 8'd0;
        end else begin
            med_prev_q <= med_prev_d;
        end
    end
`else
    assign pv_new_s = medida;
`endif

    // Error and change-of-error; the difference of two 9-bit values needs 10 bits
    always_comb begin
        e_raw_s = $signed({1'b0, sp_q}) - $signed({1'b0, pv_q});
        if (first_q) begin
            de_raw_s = 10'sd0;
        end else begin
            de_raw_s = $signed({e_sh_s[8], e_sh_s}) - $signed({err_prev_q[8], err_prev_q});
        end
    end

    fuzzy_sat_off #(.IN_W(9), .SH(SH_ERRO)) u_sat_erro (
        .din  (e_raw_s),
        .dsh  (e_sh_s),
        .dout (e_enc_s)
    );

    fuzzy_sat_off #(.IN_W(10), .SH(SH_DERRO)) u_sat_derro (
        .din  (de_raw_s),
        .dsh  (de_sh_s),
        .dout (de_enc_s)
    );

    // Sequencer next-state and datapath register updates
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sp_d       = sp_q;
        pv_d       = pv_q;
        err_prev_d = err_prev_q;
        first_d    = first_q;
        ent1_d     = ent1_q;
        ent2_d     = ent2_q;
        en_d       = en_q;
        pronto_d   = pronto_q;
`ifdef FUZZY_ENTRADA_FILTRO_EN
        med_prev_d = med_prev_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (medida_valid) begin
                    sp_d     = setpoint;
                    pv_d     = pv_new_s;
                    pronto_d = 1'b0;
                    state_d  = ST_CALC;
`ifdef FUZZY_ENTRADA_FILTRO_EN
                    med_prev_d = medida;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                ent1_d     = e_enc_s;
                ent2_d     = de_enc_s;
                err_prev_d = e_sh_s;
                first_d    = 1'b0;
                en_d       = 1'b1;
                cnt_d      = {CNT_W{1'b0}};
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_q == RUN_LAST) begin
                    en_d    = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    pronto_d = 1'b1;
                    cnt_d    = {CNT_W{1'b0}};
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                en_d     = 1'b0;
                pronto_d = 1'b1;
                cnt_d    = {CNT_W{1'b0}};
                state_d  = ST_IDLE;
            end
        endcase
    end

    // Strobes arriving while busy are dropped and counted, saturating at 255
    always_comb begin
        if (medida_valid && (state_q != ST_IDLE) && (ovr_q != 8'd255)) begin
            ovr_d = ovr_q + 8'd1;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk_0 or negedge Srst) begin
        if (!Srst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            sp_q       <= 8'd0;
            pv_q       <= 8'd0;
            err_prev_q <= 9'sd0;
            first_q    <= 1'b1;
            ent1_q     <= ZERO_OFF;
            ent2_q     <= ZERO_OFF;
            en_q       <= 1'b0;
            pronto_q   <= 1'b1;
            ovr_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sp_q       <= sp_d;
            pv_q       <= pv_d;
            err_prev_q <= err_prev_d;
            first_q    <= first_d;
            ent1_q     <= ent1_d;
            ent2_q     <= ent2_d;
            en_q       <= en_d;
            pronto_q   <= pronto_d;
            ovr_q      <= ovr_d;
        end
    end

    assign Entrada_01 = ent1_q;
    assign Entrada_02 = ent2_q;
    assign EN_REGRAS  = en_q;
    assign pronto     = pronto_q;
    assign overrun    = ovr_q;

endmodule
